// File: rtl/signal_pkg.sv
// Shared sample-format definitions for the offset-binary / two's-complement
// signal path (forward source mapping and restore converter).
package signal_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h7FF;
  localparam logic signed [SAMPLE_W-1:0] SMAX = 12'sh7FF;
  localparam logic signed [SAMPLE_W-1:0] SMIN = 12'sh800;

  // Clamped sample plus a flag telling whether clamping happened.
  typedef struct packed {
    logic                sat;
    logic [SAMPLE_W-1:0] data;
  } sat_sample_t;

  // Clamp a 13-bit signed intermediate into the 12-bit signed sample range.
  function automatic sat_sample_t sat13to12(input logic signed [SAMPLE_W:0] d);
    sat_sample_t r;
    if (d > 13'sd2047) begin
      r.sat  = 1'b1;
      r.data = SMAX;
    end else if (d < -13'sd2048) begin
      r.sat  = 1'b1;
      r.data = SMIN;
    end else begin
      r.sat  = 1'b0;
      r.data = d[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/signal_restore_stage.sv
// Generic registered pipeline stage with a valid/ready handshake.
// The stage loads whenever it is empty or its contents leave downstream.
module signal_restore_stage #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v_q;
  logic [W-1:0] data_q;
  logic         adv;

  assign adv       = !v_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q;
  assign out_data  = data_q;

  // Valid bit follows the upstream offer on advance; payload only loads on a real sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else if (adv) begin
      v_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/signal_restore.sv
// Offset-binary to two's-complement converter: subtract mid-scale (S1),
// clamp to 12-bit signed (S2), and count delivered saturated samples.
module signal_restore
  import signal_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] OFFSET = MIDSCALE,
  parameter int unsigned         CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    sat_cnt,
  input  logic                cnt_clr
);

  logic signed [SAMPLE_W:0] diff;
  logic        [SAMPLE_W:0] s1_data;
  logic                     s1_valid;
  logic                     s2_ready;
  sat_sample_t              clamped;
  logic        [SAMPLE_W:0] s2_data;
  logic        [CNT_W-1:0]  sat_cnt_q;
  logic        [CNT_W-1:0]  sat_cnt_d;

  assign diff = $signed({1'b0, in_data} - {1'b0, OFFSET});

  signal_restore_stage #(.W(SAMPLE_W + 1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (diff),
    .in_ready  (in_ready),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign clamped = sat13to12($signed(s1_data));

  signal_restore_stage #(.W(SAMPLE_W + 1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (clamped),
    .in_ready  (s2_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_sat  = s2_data[SAMPLE_W];
  assign out_data = s2_data[SAMPLE_W-1:0];
  assign sat_cnt  = sat_cnt_q;

  // Next count: clear wins, otherwise a delivered saturated sample bumps it up to all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // Saturation event counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: doc/signal_restore.md
# signal_restore

Offset-binary to two's-complement sample converter, the inverse of the signal-source offset mapping. The forward path maps signed x to x + 0x7FF; this block takes 12-bit offset-binary samples and recovers signed samples by subtracting the mid-scale code. It saturates out-of-range codes and counts saturation events. It sits between the capture/ADC side of the signal path and the signed DSP chain, with a valid/ready handshake on both sides.

## Interface
- OFFSET, 12'h7FF, mid-scale code subtracted from every input sample.
- CNT_W, 16, width of the saturation event counter.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  12  offset-binary sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  12  two's-complement sample.
- out_sat  out  1  out_data was clamped; aligned with out_data.
- out_valid  out  1  out_data/out_sat are valid.
- out_ready  in  1  downstream accepts this cycle.
- sat_cnt  out  CNT_W  number of saturated samples delivered; sticks at all-ones.
- cnt_clr  in  1  synchronous clear of sat_cnt.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage 1 (S1) registers d = {1'b0,in_data} - {1'b0,OFFSET} as a 13-bit signed value.
- Stage 2 (S2) clamps d to [-2048, +2047] and sets sat = 1 when clamping occurred.
  - With OFFSET = 0x7FF, only in_data = 0xFFF saturates (d = 2048): out_data = 0x7FF, out_sat = 1.
  - in_data 0x000 gives -2047 (0x801); in_data 0x7FF gives 0.
- Saturation counter:
  - sat_cnt increments on each output transfer with out_sat = 1.
  - Holds at 2^CNT_W-1 once reached.
  - cnt_clr has priority over increment in the same cycle: result is 0.
- Flow control uses per-stage valid bits:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is permitted.
- Stall: when out_ready = 0 and both stages are full, in_ready = 0. Data and flags hold unchanged; no sample is dropped or duplicated.
- out_data/out_sat may change only when out_valid = 0 or on an output transfer.
- in_data is don't-care when in_valid = 0; the stage valid bit clears.

## Timing
- Reset (rst = 0 at a clock edge): s1_v = s2_v = 0, out_valid = 0, out_data = 0, out_sat = 0, sat_cnt = 0. in_ready is 1 in the cycle after reset.
- Reset mid-stream discards both stages. No output transfer completes in the reset cycle.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high.
- Throughput: 1 sample/cycle sustained.
- A bubble in in_valid propagates as a one-cycle out_valid gap.
- Simultaneous input transfer and output transfer with both stages full: the pipeline shifts, S2 takes S1, and S1 takes the new sample.
- sat_cnt updates on the edge that completes the output transfer and is visible the next cycle.

## Structure
- Shared package signal_pkg:
  - SAMPLE_W = 12.
  - MIDSCALE = 12'h7FF.
  - SMAX = 12'sh7FF, SMIN = 12'sh800.
  - Function sat13to12 returning {sat, data}, also usable by the forward-path block.
- One sub-module, signal_restore_stage: a generic registered pipeline stage with valid/ready and a payload width parameter, instantiated twice.
- Top level holds the subtract, the clamp, and the counter.

## Test plan
- Reset then a stream of 0x7FF, 0x000, 0xFFE with out_ready = 1 -> out_data 0x000, 0x801, 0x7FF at cycles 2, 3, 4 after the first transfer; out_sat = 0; sat_cnt = 0.
- Input 0xFFF -> out_data 0x7FF, out_sat = 1, sat_cnt = 1 after the output transfer.
- Ten samples 0..9 with out_ready low for cycles 3-6 -> in_ready drops once both stages are full; outputs are exactly -2047..-2038 in order with no loss or duplication.
- Preload sat_cnt to 0xFFFE via 2^16-2 saturating samples, then 3 more -> sat_cnt sticks at 0xFFFF. Then cnt_clr together with a saturating transfer -> sat_cnt = 0.
- rst = 0 asserted with both stages full and out_ready = 0 -> next cycle out_valid = 0, out_data = 0, sat_cnt = 0, in_ready = 1.
- Round trip: forward mapping of x over -2047..2047 fed through the block -> out_data == x for every x, out_sat = 0.
